// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM states,
// index widths and the round-robin winner search.
package uart_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_PRESENT} arb_state_e;

  localparam int unsigned REQ_MAX  = 8;
  localparam int unsigned ID_W_MAX = $clog2(REQ_MAX);
  localparam int unsigned CAND_W   = ID_W_MAX + 1;

  typedef struct packed {
    logic                found;
    logic [ID_W_MAX-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // First valid index strictly after ptr, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [REQ_MAX-1:0]  valid,
                                       input logic [ID_W_MAX-1:0] ptr,
                                       input int unsigned         n);
    rr_pick_t          r;
    logic [CAND_W-1:0] cand;
    r = '0;
    for (int k = 1; k <= int'(REQ_MAX); k++) begin
      cand = {1'b0, ptr} + CAND_W'(k);
      if (cand >= CAND_W'(n)) cand = cand - CAND_W'(n);
      if (k <= int'(n) && !r.found && valid[cand[ID_W_MAX-1:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[ID_W_MAX-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte load interface between the arbiter (master) and the UART transmitter core (slave).
interface uart_tx_if;
  logic [7:0] tx_D;
  logic       tx_D_RYn;
  logic       tx_read;
  logic       tx_BUSYn;

  modport master (output tx_D, tx_D_RYn, input  tx_read, tx_BUSYn);
  modport slave  (input  tx_D, tx_D_RYn, output tx_read, tx_BUSYn);
endinterface

// File: rtl/uart_tx_arbiter_sync.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// sources, with CTS flow control and a per-grant burst limit.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned ID_W     = id_w(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 cts_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  uart_tx_if.master            tx,
  output logic [NUM_REQ-1:0]   grant,
  output logic [ID_W-1:0]      active_id,
  output logic                 idle
);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  arb_state_e              r_state, w_nxt;
  logic [7:0]              r_hold;
  logic [ID_W-1:0]         r_ptr, r_active, w_win_id;
  logic [3:0]              r_burst;
  logic [NUM_REQ-1:0]      r_grant, w_win_oh, w_own_oh;
  logic [NUM_REQ-1:0][7:0] w_data;
  logic                    w_cts_q, w_cts_ok, w_go, w_any, w_cont, w_unused;
  rr_pick_t                w_pick;

  // cts_n idles deasserted so nothing is presented until the line is sampled.
  sync_2ff #(.RST_VAL(1'b1)) u_cts_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (cts_n),
    .o_q   (w_cts_q)
  );

  assign w_cts_ok = ~w_cts_q;
  assign w_go     = enable & w_cts_ok;
  assign w_any    = |req_valid;
  assign w_data   = req_data;
  assign w_pick   = rr_pick(REQ_MAX'(req_valid), ID_W_MAX'(r_ptr), NUM_REQ);
  assign w_win_id = ID_W'(w_pick.idx);
  assign w_win_oh = NUM_REQ'(1) << w_win_id;
  assign w_own_oh = NUM_REQ'(1) << r_ptr;
  assign w_unused = &{1'b0, w_pick.idx};

  // Burst continuation: refill from the current owner on the read strobe itself.
  assign w_cont = (r_state == ST_PRESENT) & tx.tx_read & w_go
                & req_valid[r_ptr] & (r_burst < BURST_MAX);

  always_comb begin
    w_nxt     = r_state;
    req_ready = '0;
    case (r_state)
      ST_IDLE: if (w_go && w_any) w_nxt = ST_ARB;
      ST_ARB: begin
        if (w_pick.found) begin
          w_nxt     = ST_PRESENT;
          req_ready = w_win_oh;
        end else begin
          w_nxt = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (tx.tx_read) begin
          if (w_cont)             req_ready = w_own_oh;
          else if (w_go && w_any) w_nxt     = ST_ARB;
          else                    w_nxt     = ST_IDLE;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_hold   <= '0;
      r_ptr    <= ID_W'(NUM_REQ - 1);
      r_active <= '0;
      r_burst  <= '0;
      r_grant  <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == ST_ARB) begin
        if (w_pick.found) begin
          r_hold   <= w_data[w_win_id];
          r_ptr    <= w_win_id;
          r_active <= w_win_id;
          r_grant  <= w_win_oh;
          r_burst  <= 4'd1;
        end else begin
          r_grant <= '0;
        end
      end else if (w_cont) begin
        r_hold  <= w_data[r_ptr];
        r_burst <= r_burst + 4'd1;
      end else if (r_state == ST_PRESENT && tx.tx_read && w_nxt == ST_IDLE) begin
        r_grant <= '0;
      end
    end
  end

  assign tx.tx_D     = r_hold;
  assign tx.tx_D_RYn = ~((r_state == ST_PRESENT) & w_cts_ok);
  assign grant       = r_grant;
  assign active_id   = r_active;
  assign idle        = (r_state == ST_IDLE) & tx.tx_BUSYn;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: byte sources and a
// transmitter model drive the DUT; a monitor checks arbitration order and data.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int MB = 2;

  logic          clk = 1'b0;
  logic          rst_n, enable, cts_n;
  logic [NR-1:0] req_valid, req_ready, grant;
  logic [NR*8-1:0] req_data;
  logic [1:0]    active_id;
  logic          idle;

  uart_tx_if u_if ();

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cts_n     (cts_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (u_if),
    .grant     (grant),
    .active_id (active_id),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  int        vectors = 0, miscompares = 0;
  logic [7:0] src_q[NR][$];
  logic [7:0] exp_q[$];
  logic [NR-1:0] acc_mask = '0, src_mask = '1;
  bit        auto_src = 0, auto_tx = 0;
  int        read_req = 0, read_done = 0, busy = 0;
  int        owner = NR - 1, run = 0, m_w;
  bit        exp_low = 0, m_cont, rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid requester after 'from', wrapping.
  function automatic int rr_model(input logic [NR-1:0] v, input int from);
    for (int k = 1; k <= NR; k++)
      if (v[(from + k) % NR]) return (from + k) % NR;
    return -1;
  endfunction

  // Sources and transmitter: inputs change 1 time unit after the rising edge.
  initial begin
    u_if.tx_read = 1'b0; u_if.tx_BUSYn = 1'b1; req_valid = '0; req_data = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++)
        if (acc_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (auto_src)
        for (int i = 0; i < NR; i++)
          if (src_q[i].size() < 4 && $urandom_range(0, 2) == 0)
            src_q[i].push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = src_mask[i] && src_q[i].size() > 0 && (!auto_src || $urandom_range(0, 7) != 0);
        req_data[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
      rd = 1'b0;
      if (busy > 0) busy--;
      if (!u_if.tx_D_RYn && !u_if.tx_read) begin
        if (read_done != read_req) begin rd = 1'b1; read_done++; end
        else if (auto_tx && $urandom_range(0, 2) == 0) rd = 1'b1;
      end
      if (rd) busy = 6;
      u_if.tx_read  = rd;
      u_if.tx_BUSYn = (busy == 0) && !rd;
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); owner = NR - 1; run = 0; acc_mask = '0; exp_low = 0;
    end else begin
      acc_mask = req_ready;
      if (exp_low) begin chk("burst_gap_ryn", u_if.tx_D_RYn, 0); exp_low = 0; end
      if (!u_if.tx_D_RYn) begin
        chk("grant", grant, 32'(1) << owner);
        chk("active_id", active_id, owner);
      end
      if (u_if.tx_read && !u_if.tx_D_RYn) begin
        if (exp_q.size() == 0) chk("unexpected_delivery", u_if.tx_D, 32'hFFFF_FFFF);
        else chk("tx_D", u_if.tx_D, exp_q.pop_front());
        m_cont = enable && !cts_n && req_valid[owner] && run < MB;
        chk("burst_ready", req_ready, m_cont ? (32'(1) << owner) : 0);
        if (m_cont) begin
          exp_q.push_back(req_data[owner*8 +: 8]); run++; exp_low = 1;
        end
      end else if (req_ready != '0) begin
        m_w = rr_model(req_valid, owner);
        chk("rr_winner", req_ready, (m_w < 0) ? 0 : (32'(1) << m_w));
        if (m_w >= 0) begin
          exp_q.push_back(req_data[m_w*8 +: 8]); owner = m_w; run = 1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_rdy(input string nm);
    bit ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin cyc(1); ok = !u_if.tx_D_RYn; end
    chk(nm, ok, 1);
  endtask

  task automatic do_read(input string nm);
    bit ok = 0;
    read_req++;
    for (int c = 0; c < 40 && !ok; c++) begin cyc(1); ok = (read_done == read_req); end
    chk(nm, ok, 1);
    cyc(1);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 0;
    int pend;
    for (int c = 0; c < 400 && !ok; c++) begin
      cyc(1);
      pend = 0;
      for (int i = 0; i < NR; i++) pend += src_q[i].size();
      ok = idle && u_if.tx_D_RYn && exp_q.size() == 0 && pend == 0;
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; cts_n = 1'b0;
    #12;
    chk("rst_tx_D", u_if.tx_D, 0);
    chk("rst_D_RYn", u_if.tx_D_RYn, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_active_id", active_id, 0);
    chk("rst_idle", idle, 1);
    @(posedge clk); #2; rst_n = 1'b1;
    cyc(3);

    // Single requester, plain delivery.
    src_q[0].push_back(8'h55);
    wait_rdy("rdy_55");
    chk("hold_55", u_if.tx_D, 8'h55);
    do_read("read_55");
    wait_idle("idle_55");

    // CTS stall keeps the held byte.
    src_q[0].push_back(8'hA3);
    wait_rdy("rdy_a3");
    cts_n = 1'b1; cyc(3);
    chk("cts_stall_ryn", u_if.tx_D_RYn, 1);
    chk("cts_stall_hold", u_if.tx_D, 8'hA3);
    cts_n = 1'b0; cyc(3);
    chk("cts_resume_ryn", u_if.tx_D_RYn, 0);
    do_read("read_a3");
    wait_idle("idle_a3");

    // Random traffic: all sources, then only 1 and 3.
    auto_src = 1; auto_tx = 1; src_mask = 4'hF;
    cyc(600);
    src_mask = 4'b1010;
    cyc(300);
    auto_src = 0; src_mask = 4'hF;
    wait_idle("drain_random");

    // enable=0 still delivers the held byte but accepts nothing new.
    auto_tx = 0;
    src_q[0].push_back(8'h3C); src_q[0].push_back(8'h3D);
    wait_rdy("rdy_3c");
    enable = 1'b0; cyc(1);
    do_read("read_3c");
    cyc(2);
    chk("dis_grant", grant, 0);
    chk("dis_ryn", u_if.tx_D_RYn, 1);
    enable = 1'b1;
    wait_rdy("rdy_3d");
    chk("hold_3d", u_if.tx_D, 8'h3D);
    auto_tx = 1;
    wait_idle("idle_3d");

    // Reset while presenting; requester 0 must win first afterwards.
    auto_tx = 0;
    src_q[2].push_back(8'h11);
    wait_rdy("rdy_11");
    src_q[0].push_back(8'hA0); src_q[1].push_back(8'hB1);
    cyc(2);
    @(posedge clk); #3; rst_n = 1'b0; #1;
    chk("mid_rst_tx_D", u_if.tx_D, 0);
    chk("mid_rst_ryn", u_if.tx_D_RYn, 1);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_active", active_id, 0);
    chk("mid_rst_ready", req_ready, 0);
    cyc(2); rst_n = 1'b1;
    wait_rdy("rdy_after_rst");
    chk("rst_first_win", grant, 4'b0001);
    chk("rst_first_byte", u_if.tx_D, 8'hA0);
    auto_tx = 1;
    wait_idle("drain_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
